// File: rtl/csr_pkg.sv
// Shared address map helpers, access decode and byte-enable expansion for the
// control/status register bank.
package csr_pkg;

  // Widest register supported by the byte-mask helper; callers cast down.
  localparam int CSR_MAX_DW = 256;
  localparam int CSR_MAX_BE = CSR_MAX_DW / 8;

  typedef enum logic [2:0] {
    CSR_NONE   = 3'd0,
    CSR_STATUS = 3'd1,
    CSR_EVT    = 3'd2,
    CSR_MASK   = 3'd3,
    CSR_CTRL   = 3'd4
  } csr_kind_e;

  function automatic int evt_addr(input int num_status);
    return num_status;
  endfunction

  function automatic int mask_addr(input int num_status);
    return num_status + 1;
  endfunction

  function automatic int ctrl_base(input int num_status);
    return num_status + 2;
  endfunction

  function automatic int num_ctrl(input int num_regs, input int num_status);
    return num_regs - num_status - 2;
  endfunction

  function automatic csr_kind_e csr_decode(input int addr, input int num_status,
                                           input int num_regs);
    if (addr < num_status)          return CSR_STATUS;
    if (addr == evt_addr(num_status))  return CSR_EVT;
    if (addr == mask_addr(num_status)) return CSR_MASK;
    if (addr < num_regs)            return CSR_CTRL;
    return CSR_NONE;
  endfunction

  function automatic logic [CSR_MAX_DW-1:0] be_to_mask(input logic [CSR_MAX_BE-1:0] be);
    logic [CSR_MAX_DW-1:0] m;
    m = '0;
    for (int b = 0; b < CSR_MAX_BE; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_bank_if.sv
// Host-side write/read bus of the register bank.
interface csr_bank_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                    host_we;
  logic [ADDR_WIDTH-1:0]   host_wr_addr;
  logic [DATA_WIDTH-1:0]   host_wr_data;
  logic [DATA_WIDTH/8-1:0] host_be;
  logic                    host_re;
  logic [ADDR_WIDTH-1:0]   host_rd_addr;
  logic [DATA_WIDTH-1:0]   host_rd_data;
  logic                    host_rd_valid;
  logic                    host_done;
  logic                    host_err;

  modport master (
    output host_we, host_wr_addr, host_wr_data, host_be, host_re, host_rd_addr,
    input  host_rd_data, host_rd_valid, host_done, host_err
  );

  modport slave (
    input  host_we, host_wr_addr, host_wr_data, host_be, host_re, host_rd_addr,
    output host_rd_data, host_rd_valid, host_done, host_err
  );
endinterface

// File: rtl/csr_event_capture.sv
// Rising-edge detector feeding a sticky write-1-to-clear event register;
// a new edge in the same cycle as a clear keeps the bit set.
module csr_event_capture #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sys_event,
  input  logic                  clr_en,
  input  logic [DATA_WIDTH-1:0] clr_mask,
  output logic [DATA_WIDTH-1:0] evt
);

  logic [DATA_WIDTH-1:0] sys_event_d_reg;
  logic [DATA_WIDTH-1:0] evt_reg;
  logic [DATA_WIDTH-1:0] evt_next;
  logic [DATA_WIDTH-1:0] rise;

  assign rise = sys_event & ~sys_event_d_reg;

  always_comb begin
    evt_next = evt_reg;
    if (clr_en) begin
      evt_next = evt_next & ~clr_mask;
    end
    evt_next = evt_next | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_event_d_reg <= '0;
      evt_reg         <= '0;
    end else begin
      sys_event_d_reg <= sys_event;
      evt_reg         <= evt_next;
    end
  end

  assign evt = evt_reg;

endmodule

// File: rtl/csr_bank.sv
// Host control/status register bank: sampled status words, sticky event
// register with mask and interrupt, and byte-enabled control words.
module csr_bank
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_STATUS = 2,
  localparam int NUM_CTRL  = num_ctrl(NUM_REGS, NUM_STATUS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  csr_bank_if.slave                        bus,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] sys_status,
  input  logic [DATA_WIDTH-1:0]            sys_event,
  output logic [NUM_CTRL*DATA_WIDTH-1:0]   ctrl_out,
  output logic                             irq
);

  localparam int CTRL_BASE = ctrl_base(NUM_STATUS);
  localparam int ADDR_SPAN = 2 ** ADDR_WIDTH;

  csr_kind_e             wr_kind;
  csr_kind_e             rd_kind;
  logic                  wr_bad;
  logic                  rd_bad;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] evt;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [NUM_STATUS*DATA_WIDTH-1:0] status_reg;
  logic [DATA_WIDTH-1:0]            mask_reg;
  logic [DATA_WIDTH-1:0]            mask_next;
  logic                             irq_reg;
  logic [DATA_WIDTH-1:0]            rd_data_reg;
  logic                             rd_valid_reg;
  logic                             done_reg;
  logic                             err_reg;

  // Every address slot, out-of-range ones tied to zero, for the read mux.
  logic [ADDR_SPAN*DATA_WIDTH-1:0]  reg_flat;

  assign wr_kind = csr_decode(int'(bus.host_wr_addr), NUM_STATUS, NUM_REGS);
  assign rd_kind = csr_decode(int'(bus.host_rd_addr), NUM_STATUS, NUM_REGS);
  assign wr_bad  = bus.host_we && (wr_kind == CSR_STATUS || wr_kind == CSR_NONE);
  assign rd_bad  = bus.host_re && (rd_kind == CSR_NONE);
  assign wr_mask = DATA_WIDTH'(be_to_mask(CSR_MAX_BE'(bus.host_be)));

  csr_event_capture #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_event (
    .clk       (clk),
    .rst_n     (rst_n),
    .sys_event (sys_event),
    .clr_en    (bus.host_we && wr_kind == CSR_EVT),
    .clr_mask  (bus.host_wr_data & wr_mask),
    .evt       (evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_reg <= '0;
    end else begin
      status_reg <= sys_status;
    end
  end

  assign mask_next = (mask_reg & ~wr_mask) | (bus.host_wr_data & wr_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      if (bus.host_we && wr_kind == CSR_MASK) begin
        mask_reg <= mask_next;
      end
      irq_reg <= |(evt & mask_reg);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
      logic [DATA_WIDTH-1:0] word_reg;
      logic [DATA_WIDTH-1:0] word_next;
      logic                  hit;

      assign hit       = bus.host_we && (bus.host_wr_addr == ADDR_WIDTH'(CTRL_BASE + gi));
      assign word_next = (word_reg & ~wr_mask) | (bus.host_wr_data & wr_mask);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (hit) begin
          word_reg <= word_next;
        end
      end

      assign ctrl_out[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
    end

    for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_view
      if (gi < NUM_STATUS) begin : g_stat
        assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = status_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      end else if (gi == NUM_STATUS) begin : g_evt
        assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = evt;
      end else if (gi == NUM_STATUS + 1) begin : g_mask
        assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = mask_reg;
      end else if (gi < NUM_REGS) begin : g_ctl
        assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] =
            ctrl_out[(gi-CTRL_BASE)*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_none
        assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < ADDR_SPAN; i++) begin
      if (bus.host_rd_addr == ADDR_WIDTH'(i)) begin
        rd_mux = reg_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read data is taken from current register state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= bus.host_re;
      done_reg     <= bus.host_we;
      err_reg      <= wr_bad || rd_bad;
      if (bus.host_re) begin
        rd_data_reg <= rd_bad ? '0 : rd_mux;
      end
    end
  end

  assign bus.host_rd_data  = rd_data_reg;
  assign bus.host_rd_valid = rd_valid_reg;
  assign bus.host_done     = done_reg;
  assign bus.host_err      = err_reg;
  assign irq               = irq_reg;

endmodule

// File: tb/tb_csr_bank.sv
// Scoreboard bench for csr_bank (6 registers: status 0..1, EVT 2, MASK 3, CTRL 4..5).
module tb_csr_bank;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 6;
  localparam int NS = 2;
  localparam int NC = NR - NS - 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*DW-1:0]  sys_status;
  logic [DW-1:0]     sys_event;
  logic [NC*DW-1:0]  ctrl_out;
  logic              irq;

  csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  csr_bank #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .NUM_STATUS (NS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sys_status (sys_status),
    .sys_event  (sys_event),
    .ctrl_out   (ctrl_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive request, queue expectation, check the response after the edge.
  task automatic bus_step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [3:0] be, input bit re, input logic [AW-1:0] ra,
                          input logic [DW-1:0] exp_rd, input bit exp_err);
    exp_t e;
    exp_t o;
    bus.host_we      = we;
    bus.host_wr_addr = wa;
    bus.host_wr_data = wd;
    bus.host_be      = be;
    bus.host_re      = re;
    bus.host_rd_addr = ra;
    e.rd = re;
    e.wr = we;
    e.data = exp_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.host_we = 1'b0;
    bus.host_re = 1'b0;
    o = exp_q.pop_front();
    check("rd_valid", 64'(bus.host_rd_valid), 64'(o.rd));
    check("done", 64'(bus.host_done), 64'(o.wr));
    check("err", 64'(bus.host_err), 64'(o.err));
    if (o.rd) check("rd_data", 64'(bus.host_rd_data), 64'(o.data));
    $display("txn we=%0b wa=%0d wd=%h be=%b re=%0b ra=%0d -> rd_valid=%0b rd_data=%h done=%0b err=%0b irq=%0b",
             we, wa, wd, be, re, ra, bus.host_rd_valid, bus.host_rd_data,
             bus.host_done, bus.host_err, irq);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be,
                    input bit exp_err);
    bus_step(1'b1, a, d, be, 1'b0, '0, '0, exp_err);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input bit exp_err);
    bus_step(1'b0, '0, '0, '0, 1'b1, a, exp_d, exp_err);
  endtask

  task automatic idle();
    bus_step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sys_status = '0;
    sys_event = '0;
    bus.host_we = 1'b0;
    bus.host_wr_addr = '0;
    bus.host_wr_data = '0;
    bus.host_be = '0;
    bus.host_re = 1'b0;
    bus.host_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", 64'(bus.host_rd_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(AW'(a), '0, (a >= NR));

    // Byte-enabled control writes
    wr(3'd4, 32'hAABBCCDD, 4'b1111, 1'b0);
    check("ctrl0_full", 64'(ctrl_out[31:0]), 64'hAABBCCDD);
    wr(3'd4, 32'h11223344, 4'b0101, 1'b0);
    check("ctrl0_be", 64'(ctrl_out[31:0]), 64'hAA22CC44);
    wr(3'd5, 32'h12345678, 4'b1000, 1'b0);
    check("ctrl1_be", 64'(ctrl_out[63:32]), 64'h12000000);
    rd(3'd4, 32'hAA22CC44, 1'b0);
    rd(3'd5, 32'h12000000, 1'b0);

    // Status reads and illegal accesses
    sys_status = {32'h0000BEEF, 32'hCAFE0001};
    idle();
    wr(3'd0, 32'hFFFFFFFF, 4'b1111, 1'b1);
    rd(3'd0, 32'hCAFE0001, 1'b0);
    rd(3'd1, 32'h0000BEEF, 1'b0);
    rd(3'd7, 32'h0, 1'b1);
    bus_step(1'b1, 3'd6, 32'hFFFFFFFF, 4'b1111, 1'b1, 3'd7, 32'h0, 1'b1);
    check("illegal_no_change", 64'(ctrl_out), 64'h12000000_AA22CC44);
    bus_step(1'b1, 3'd1, 32'hFFFFFFFF, 4'b1111, 1'b1, 3'd1, 32'h0000BEEF, 1'b1);
    sys_status[63:32] = 32'h00001234;
    rd(3'd1, 32'h0000BEEF, 1'b0);
    rd(3'd1, 32'h00001234, 1'b0);

    // Event capture and interrupt
    wr(3'd3, 32'h1, 4'b1111, 1'b0);
    sys_event = 32'h1;
    idle();
    check("irq_lag", 64'(irq), 64'd0);
    idle();
    check("irq_set", 64'(irq), 64'd1);
    repeat (3) idle();
    rd(3'd2, 32'h1, 1'b0);
    rd(3'd2, 32'h1, 1'b0);
    wr(3'd2, 32'h1, 4'b1111, 1'b0);
    check("irq_clr_lag", 64'(irq), 64'd1);
    idle();
    check("irq_clr", 64'(irq), 64'd0);
    rd(3'd2, 32'h0, 1'b0);
    sys_event = 32'h0;
    idle();
    sys_event = 32'h1;
    wr(3'd2, 32'h1, 4'b1111, 1'b0);
    rd(3'd2, 32'h1, 1'b0);
    sys_event = 32'h0;
    idle();
    sys_event = 32'h1;
    wr(3'd2, 32'h1, 4'b1111, 1'b0);
    rd(3'd2, 32'h1, 1'b0);
    wr(3'd2, 32'h1, 4'b1110, 1'b0);
    rd(3'd2, 32'h1, 1'b0);
    wr(3'd2, 32'h1, 4'b0001, 1'b0);
    rd(3'd2, 32'h0, 1'b0);
    sys_event = 32'h201;
    idle();
    idle();
    check("irq_masked", 64'(irq), 64'd0);
    wr(3'd3, 32'h00000200, 4'b0010, 1'b0);
    check("irq_mask_lag", 64'(irq), 64'd0);
    idle();
    check("irq_mask_set", 64'(irq), 64'd1);
    rd(3'd3, 32'h201, 1'b0);
    rd(3'd2, 32'h200, 1'b0);

    // Same-cycle write and read
    wr(3'd4, 32'd5, 4'b1111, 1'b0);
    bus_step(1'b1, 3'd4, 32'd9, 4'b1111, 1'b1, 3'd4, 32'd5, 1'b0);
    rd(3'd4, 32'd9, 1'b0);

    // Reset while a read response is on the bus
    bus.host_re = 1'b1;
    bus.host_rd_addr = 3'd4;
    @(posedge clk);
    #1;
    bus.host_re = 1'b0;
    check("pre_rst_valid", 64'(bus.host_rd_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    sys_event = '0;
    sys_status = '0;
    #1;
    check("rst_kill_valid", 64'(bus.host_rd_valid), 64'd0);
    check("rst_kill_irq", 64'(irq), 64'd0);
    check("rst_kill_ctrl", 64'(ctrl_out), 64'd0);
    check("rst_kill_data", 64'(bus.host_rd_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(AW'(a), '0, (a >= NR));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Parametrised host-to-system control/status register bank for the button/robot control path. Successor to the two-register button register file.
- Provides multiple read-only status words sampled from the system side, and a sticky event register with write-1-to-clear and edge capture.
- Also provides an interrupt mask, N read/write control words with byte-enable writes, registered reads with a valid strobe, and write/error completion pulses.

Parameters:
- DATA_WIDTH, 32, width of every register; must be a multiple of 8.
- NUM_REGS, 8, total register count; must satisfy NUM_REGS >= NUM_STATUS+3.
- ADDR_WIDTH, 3, host address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- NUM_STATUS, 2, read-only status words at addresses 0..NUM_STATUS-1.
- Derived: NUM_CTRL = NUM_REGS-NUM_STATUS-2; EVT_ADDR = NUM_STATUS; MASK_ADDR = NUM_STATUS+1; CTRL_BASE = NUM_STATUS+2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- host_we  in  1  write request, one beat per high cycle
- host_wr_addr  in  ADDR_WIDTH  write address
- host_wr_data  in  DATA_WIDTH  write data
- host_be  in  DATA_WIDTH/8  byte enables for the write
- host_re  in  1  read request
- host_rd_addr  in  ADDR_WIDTH  read address
- host_rd_data  out  DATA_WIDTH  registered read data
- host_rd_valid  out  1  one-cycle strobe marking host_rd_data valid
- host_done  out  1  one-cycle pulse acknowledging a write
- host_err  out  1  one-cycle pulse for an illegal access
- sys_status  in  NUM_STATUS*DATA_WIDTH  system status words; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- sys_event  in  DATA_WIDTH  synchronous event lines from the system
- ctrl_out  out  NUM_CTRL*DATA_WIDTH  control words to the system
- irq  out  1  level interrupt, OR-reduction of (event & mask)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, all registers, sampled status, event-edge history, host_rd_data, host_rd_valid, host_done, host_err and irq go to 0. A reset mid-read kills the pending host_rd_valid.
- Status sampling: each status word is registered every cycle from sys_status. Reads see the value sampled in the previous cycle (1-cycle staleness is acceptable).
- Event capture:
  - sys_event_d <= sys_event each cycle.
  - Bit i of EVT sets when sys_event[i] & ~sys_event_d[i] (rising edge). The bit stays set until cleared.
  - A write to EVT_ADDR clears the bits where host_wr_data[i] is 1 and the covering byte is enabled.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- MASK and CTRL writes: each byte b is updated only when host_be[b]=1. Other bytes hold. ctrl_out is driven directly from the CTRL registers, with zero added latency after the write edge.
- irq = |(EVT & MASK), registered. It asserts 1 cycle after the edge that sets EVT or MASK.
- Write completion:
  - host_done pulses 1 cycle after every host_we cycle, legal or not.
  - host_err pulses in the same cycle as host_done if the write targets a status address or an address >= NUM_REGS.
  - Illegal writes change no state.
- Reads:
  - Latency 1. In the cycle after host_re, host_rd_valid=1 and host_rd_data holds the value of the addressed register before any same-cycle write (read-before-write).
  - An address >= NUM_REGS returns 0 and pulses host_err with host_rd_valid.
  - host_rd_data holds its value between reads.
  - Reading EVT does not clear it.
- Simultaneous host_we and host_re: both are accepted in the same cycle. If the two errors coincide, a single host_err pulse is produced.
- Back-to-back: a new request is accepted every cycle, with no stall.

Decomposition:
- Shared package csr_pkg holds:
  - the address-offset functions EVT_ADDR, MASK_ADDR, CTRL_BASE;
  - the NUM_CTRL derivation;
  - the byte-mask expansion function be_to_mask(be) -> DATA_WIDTH mask.
- One sub-module, csr_event_capture: edge detect plus sticky W1C register, with set-wins priority. Parameter DATA_WIDTH.

Test Plan:
- Reset/defaults: assert rst_n=0 mid-read -> host_rd_valid, irq, ctrl_out all 0 immediately; after release, reading every address returns 0.
- Byte-enable write: write CTRL_BASE=0xAABBCCDD with be=4'b1111, then 0x11223344 with be=4'b0101 -> ctrl_out word0=0xAA22CC44; host_done pulses each time and host_err stays 0.
- Illegal access: write addr 0 (status) -> host_done=1, host_err=1, and a status read still returns sys_status word0. Read addr 7 with NUM_REGS=6 -> host_rd_data=0, host_rd_valid=1, host_err=1.
- Event/IRQ: MASK=0x1; sys_event[0] low->high held 5 cycles -> EVT=0x1 (set once), irq=1 one cycle later. Write EVT=0x1 -> EVT=0, irq=0. A new rising edge in the clear cycle -> EVT stays 0x1.
- Status read latency: sys_status word1=0x0000BEEF, issue host_re on addr 1 -> next cycle host_rd_valid=1 and host_rd_data=0x0000BEEF.
- Read/write same cycle: CTRL_BASE=5; write 9 and read the same address in one cycle -> read returns 5; the next read returns 9.
